// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle CPU datapath for the 16-bit ISA with req/ack imem and dmem ports.
// Define DATAPATH_MC_OVF_TRAP_EN to halt with Trap on signed overflow of ADD/SUB/ADDI.
module datapath_mc #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned DADDR_W = 16
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  output logic               ImemReq,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic [15:0]        ImemRdata,
  input  logic               ImemAck,
  output logic               DmemReq,
  output logic               DmemWe,
  output logic [DADDR_W-1:0] DmemAddr,
  output logic [DATA_W-1:0]  DmemWdata,
  input  logic [DATA_W-1:0]  DmemRdata,
  input  logic               DmemAck,
  output logic               Busy,
  output logic               Halted,
  output logic               Trap,
  output logic               Retire,
  output logic [PC_W-1:0]    PcOut,
  input  logic [1:0]         DbgRegAddr,
  output logic [DATA_W-1:0]  DbgRegData
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  localparam logic [3:0] OpRType = 4'h0;
  localparam logic [3:0] OpAddi  = 4'h1;
  localparam logic [3:0] OpLw    = 4'h2;
  localparam logic [3:0] OpSw    = 4'h3;
  localparam logic [3:0] OpBeq   = 4'h4;
  localparam logic [3:0] OpHalt  = 4'hF;

  state_e              r_state, w_state_d;
  logic [PC_W-1:0]     r_pc;
  logic [15:0]         r_ir;
  logic [DATA_W-1:0]   r_a, r_b, r_alu, r_mdr;
  logic [DATA_W-1:0]   r_rf [4];
  logic                r_retire, w_retire_d;

  logic [3:0]          w_op;
  logic [1:0]          w_rs, w_rt, w_rd, w_funct;
  logic                w_is_rtype, w_known;
  logic [DATA_W-1:0]   w_imm_d, w_opnd_b, w_sum, w_diff, w_alu, w_wb_data;
  logic [PC_W-1:0]     w_imm_pc;
  logic [1:0]          w_wb_dst;
  logic                w_ovf;

  assign w_op       = r_ir[15:12];
  assign w_rs       = r_ir[11:10];
  assign w_rt       = r_ir[9:8];
  assign w_rd       = r_ir[6:5];
  assign w_funct    = r_ir[1:0];
  assign w_imm_d    = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
  assign w_imm_pc   = {{(PC_W-8){r_ir[7]}}, r_ir[7:0]};
  assign w_is_rtype = (w_op == OpRType);
  assign w_known    = (w_op == OpRType) || (w_op == OpAddi) || (w_op == OpLw) ||
                      (w_op == OpSw) || (w_op == OpBeq);

  // Non-R-type operations only ever add the immediate (ADDI and address generation).
  assign w_opnd_b = w_is_rtype ? r_b : w_imm_d;
  assign w_sum    = r_a + w_opnd_b;
  assign w_diff   = r_a - r_b;

  always_comb begin
    w_alu = w_sum;
    if (w_is_rtype) begin
      case (w_funct)
        2'b01:   w_alu = w_diff;
        2'b10:   w_alu = r_a & r_b;
        2'b11:   w_alu = r_a | r_b;
        default: w_alu = w_sum;
      endcase
    end
  end

`ifdef DATAPATH_MC_OVF_TRAP_EN
  logic w_add_ovf, w_sub_ovf, w_trap_d, r_trap;
  assign w_add_ovf = (r_a[DATA_W-1] == w_opnd_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
  assign w_sub_ovf = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
  assign w_ovf     = ((w_op == OpAddi) && w_add_ovf) ||
                     (w_is_rtype && (((w_funct == 2'b00) && w_add_ovf) ||
                                     ((w_funct == 2'b01) && w_sub_ovf)));
  assign w_trap_d  = (r_state == StExec) && w_ovf;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)      r_trap <= 1'b0;
    else if (w_trap_d) r_trap <= 1'b1;
  end
  assign Trap = r_trap;
`else
  assign w_ovf = 1'b0;
  assign Trap  = 1'b0;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_retire_d = 1'b0;
    case (r_state)
      StIdle:   if (Start) w_state_d = StFetch;
      StFetch:  if (ImemAck) w_state_d = StDecode;
      StDecode: begin
        if (w_op == OpHalt) w_state_d = StHalt;
        else if (w_known)   w_state_d = StExec;
        else begin
          w_state_d  = StFetch;
          w_retire_d = 1'b1;
        end
      end
      StExec: begin
        if (w_ovf)                               w_state_d = StHalt;
        else if ((w_op == OpLw) || (w_op == OpSw)) w_state_d = StMem;
        else if (w_op == OpBeq) begin
          w_state_d  = StFetch;
          w_retire_d = 1'b1;
        end else                                 w_state_d = StWb;
      end
      StMem: begin
        if (DmemAck) begin
          if (w_op == OpLw) w_state_d = StWb;
          else begin
            w_state_d  = StFetch;
            w_retire_d = 1'b1;
          end
        end
      end
      StWb: begin
        w_state_d  = StFetch;
        w_retire_d = 1'b1;
      end
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  assign w_wb_dst  = w_is_rtype ? w_rd : w_rt;
  assign w_wb_data = (w_op == OpLw) ? r_mdr : r_alu;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_alu    <= '0;
      r_mdr    <= '0;
      r_retire <= 1'b0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      r_retire <= w_retire_d;
      case (r_state)
        StFetch: begin
          if (ImemAck) begin
            r_ir <= ImemRdata;
            r_pc <= r_pc + PC_W'(1);
          end
        end
        StDecode: begin
          r_a <= r_rf[w_rs];
          r_b <= r_rf[w_rt];
        end
        StExec: begin
          r_alu <= w_alu;
          // PC already points past the branch, so the target is PC+1+imm overall.
          if ((w_op == OpBeq) && (r_a == r_b)) r_pc <= r_pc + w_imm_pc;
        end
        StMem:   if (DmemAck && (w_op == OpLw)) r_mdr <= DmemRdata;
        StWb:    r_rf[w_wb_dst] <= w_wb_data;
        default: ;
      endcase
    end
  end

  assign ImemReq    = (r_state == StFetch);
  assign ImemAddr   = r_pc;
  assign PcOut      = r_pc;
  assign DmemReq    = (r_state == StMem);
  assign DmemWe     = (r_state == StMem) && (w_op == OpSw);
  assign DmemAddr   = r_alu[DADDR_W-1:0];
  assign DmemWdata  = r_b;
  assign Busy       = (r_state != StIdle) && (r_state != StHalt);
  assign Halted     = (r_state == StHalt);
  assign Retire     = r_retire;
  assign DbgRegData = r_rf[DbgRegAddr];

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed-vector bench for datapath_mc with req/ack memory models.
module tb_datapath_mc;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 16;
  localparam int unsigned AW = 16;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic          ImemReq, ImemAck;
  logic [PW-1:0] ImemAddr;
  logic [15:0]   ImemRdata;
  logic          DmemReq, DmemWe, DmemAck;
  logic [AW-1:0] DmemAddr;
  logic [DW-1:0] DmemWdata, DmemRdata;
  logic          Busy, Halted, Trap, Retire;
  logic [PW-1:0] PcOut;
  logic [1:0]    DbgRegAddr = 2'd0;
  logic [DW-1:0] DbgRegData;

  datapath_mc #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .ImemAck(ImemAck),
    .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWdata(DmemWdata),
    .DmemRdata(DmemRdata), .DmemAck(DmemAck),
    .Busy(Busy), .Halted(Halted), .Trap(Trap), .Retire(Retire), .PcOut(PcOut),
    .DbgRegAddr(DbgRegAddr), .DbgRegData(DbgRegData)
  );

  always #5 Clock = ~Clock;

  // Memory models: ack after a programmable number of wait cycles; 0x20 is a fixed ROM word.
  logic [15:0]   imem [64];
  logic [DW-1:0] dmem [64];
  int imem_dly = 0, dmem_dly = 0, icnt = 0, dcnt = 0;

  assign ImemAck   = ImemReq && (icnt >= imem_dly);
  assign ImemRdata = imem[ImemAddr[5:0]];
  assign DmemAck   = DmemReq && (dcnt >= dmem_dly);
  assign DmemRdata = (DmemAddr == 16'h0020) ? 16'h7FFF : dmem[DmemAddr[5:0]];

  always @(posedge Clock) begin
    icnt <= (ImemReq && !ImemAck) ? icnt + 1 : 0;
    dcnt <= (DmemReq && !DmemAck) ? dcnt + 1 : 0;
    if (DmemReq && DmemAck && DmemWe) dmem[DmemAddr[5:0]] <= DmemWdata;
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int            n_ret = 0, st_req = 0, ld_req = 0, bad_daddr = 0, bad_wdata = 0;
  int            ret_cyc [64];
  logic [PW-1:0] ret_pc [64];

  always @(negedge Clock) begin
    if (!Reset_n) begin
      n_ret <= 0; st_req <= 0; ld_req <= 0; bad_daddr <= 0; bad_wdata <= 0;
    end else begin
      if (Retire) begin
        if (n_ret < 64) begin
          ret_cyc[n_ret] <= cyc;
          ret_pc[n_ret]  <= PcOut;
        end
        n_ret <= n_ret + 1;
      end
      if (DmemReq) begin
        if (DmemWe) st_req <= st_req + 1;
        else        ld_req <= ld_req + 1;
        if (DmemAddr != 16'd4) bad_daddr <= bad_daddr + 1;
        if (DmemWe && (DmemWdata != 16'd5)) bad_wdata <= bad_wdata + 1;
      end
    end
  end

  int n_vec = 0, n_bad = 0, start_cyc = 0;
  localparam logic [15:0] NOP  = 16'h5000;
  localparam logic [15:0] HALT = 16'hF000;

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] rs,
                                        input logic [1:0] rt, input logic [7:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [1:0] rs, input logic [1:0] rt,
                                        input logic [1:0] rd, input logic [1:0] fn);
    return {4'h0, rs, rt, 1'b0, rd, 3'b000, fn};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Start = 1'b0;
    Reset_n = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = HALT;
  endtask

  task automatic start_cpu();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    start_cyc = cyc;
    #1;
  endtask

  task automatic wait_halt(input int limit, output bit ok);
    for (int i = 0; i < limit && !Halted; i++) tick(1);
    tick(3);
    ok = Halted;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    do_reset();
    flags = {ImemReq, DmemReq, DmemWe, Busy, Halted, Trap, Retire};
    n_vec++;
    if (flags !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000000", flags);
    end
    n_vec++;
    if ({PcOut, ImemAddr, DmemAddr, DmemWdata} !== 64'h0) begin
      n_bad++; $display("FAIL reset_buses pc=%h ia=%h da=%h wd=%h want 0", PcOut, ImemAddr,
                        DmemAddr, DmemWdata);
    end
    for (int r = 0; r < 4; r++) begin
      DbgRegAddr = 2'(r); #1;
      n_vec++;
      if (DbgRegData !== 16'h0) begin
        n_bad++; $display("FAIL reset_R%0d got %h want 0000", r, DbgRegData);
      end
    end
  endtask

  task automatic test_addi();
    bit ok;
    do_reset();
    imem[0] = enc_i(4'h1, 2'd0, 2'd1, 8'd5);
    imem[1] = enc_i(4'h1, 2'd0, 2'd2, 8'hFD);
    start_cpu();
    wait_halt(200, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL addi_halt got %b want 1", ok); end
    n_vec++;
    if (n_ret !== 2) begin n_bad++; $display("FAIL addi_retires got %0d want 2", n_ret); end
    n_vec++;
    if (ret_cyc[0] - start_cyc !== 4) begin
      n_bad++; $display("FAIL addi_latency got %0d want 4", ret_cyc[0] - start_cyc);
    end
    n_vec++;
    if (ret_cyc[1] - ret_cyc[0] !== 4) begin
      n_bad++; $display("FAIL addi_spacing got %0d want 4", ret_cyc[1] - ret_cyc[0]);
    end
    n_vec++;
    if (ret_pc[1] !== 16'd2) begin n_bad++; $display("FAIL addi_pc got %h want 0002", ret_pc[1]); end
    DbgRegAddr = 2'd1; #1;
    n_vec++;
    if (DbgRegData !== 16'h0005) begin n_bad++; $display("FAIL addi_R1 got %h want 0005", DbgRegData); end
    DbgRegAddr = 2'd2; #1;
    n_vec++;
    if (DbgRegData !== 16'hFFFD) begin n_bad++; $display("FAIL addi_R2 got %h want FFFD", DbgRegData); end
  endtask

  task automatic test_rtype();
    bit ok;
    logic [DW-1:0] exp_r [4];
    do_reset();
    imem[0] = enc_i(4'h1, 2'd0, 2'd1, 8'd5);
    imem[1] = enc_i(4'h1, 2'd0, 2'd2, 8'hFD);
    imem[2] = enc_r(2'd1, 2'd2, 2'd3, 2'b01);   // SUB r3 = 5 - (-3)
    imem[3] = enc_r(2'd1, 2'd2, 2'd0, 2'b11);   // OR  r0 = 5 | FFFD
    imem[4] = enc_r(2'd0, 2'd3, 2'd2, 2'b10);   // AND r2 = FFFD & 8
    imem[5] = enc_r(2'd1, 2'd3, 2'd1, 2'b00);   // ADD r1 = 5 + 8
    exp_r = '{16'hFFFD, 16'h000D, 16'h0008, 16'h0008};
    start_cpu();
    wait_halt(300, ok);
    n_vec++;
    if (n_ret !== 6) begin n_bad++; $display("FAIL rtype_retires got %0d want 6", n_ret); end
    n_vec++;
    if (ret_cyc[5] - ret_cyc[4] !== 4) begin
      n_bad++; $display("FAIL rtype_spacing got %0d want 4", ret_cyc[5] - ret_cyc[4]);
    end
    for (int r = 0; r < 4; r++) begin
      DbgRegAddr = 2'(r); #1;
      n_vec++;
      if (DbgRegData !== exp_r[r]) begin
        n_bad++; $display("FAIL rtype_R%0d got %h want %h", r, DbgRegData, exp_r[r]);
      end
    end
  endtask

  task automatic test_mem();
    bit ok;
    do_reset();
    dmem_dly = 3;
    imem[0] = enc_i(4'h1, 2'd0, 2'd1, 8'd5);
    imem[1] = enc_i(4'h3, 2'd0, 2'd1, 8'd4);    // SW r1,4(r0)
    imem[2] = enc_i(4'h2, 2'd0, 2'd2, 8'd4);    // LW r2,4(r0)
    start_cpu();
    wait_halt(300, ok);
    n_vec++;
    if (st_req !== 4 || ld_req !== 4) begin
      n_bad++; $display("FAIL mem_req_cycles got st=%0d ld=%0d want 4/4", st_req, ld_req);
    end
    n_vec++;
    if (bad_daddr !== 0 || bad_wdata !== 0) begin
      n_bad++; $display("FAIL mem_addr_data got bad_addr=%0d bad_wdata=%0d want 0/0", bad_daddr,
                        bad_wdata);
    end
    n_vec++;
    if (n_ret !== 3) begin n_bad++; $display("FAIL mem_retires got %0d want 3", n_ret); end
    n_vec++;
    if (ret_cyc[1] - ret_cyc[0] !== 7) begin
      n_bad++; $display("FAIL sw_latency got %0d want 7", ret_cyc[1] - ret_cyc[0]);
    end
    n_vec++;
    if (ret_cyc[2] - ret_cyc[1] !== 8) begin
      n_bad++; $display("FAIL lw_latency got %0d want 8", ret_cyc[2] - ret_cyc[1]);
    end
    DbgRegAddr = 2'd2; #1;
    n_vec++;
    if (DbgRegData !== 16'h0005) begin n_bad++; $display("FAIL lw_R2 got %h want 0005", DbgRegData); end
    n_vec++;
    if ({DmemReq, DmemWe} !== 2'b00) begin
      n_bad++; $display("FAIL mem_idle got %b want 00", {DmemReq, DmemWe});
    end
    dmem_dly = 0;
  endtask

  task automatic test_beq();
    bit ok;
    int k;
    do_reset();
    imem[0] = enc_i(4'h1, 2'd0, 2'd1, 8'd7);
    for (int i = 1; i < 10; i++) imem[i] = NOP;
    imem[10] = enc_i(4'h4, 2'd1, 2'd1, 8'hFF);  // BEQ r1,r1,-1: spins at 10
    start_cpu();
    tick(80);
    n_vec++;
    if (n_ret < 14 || n_ret > 63) begin
      n_bad++; $display("FAIL beq_loop_retires got %0d want 14..63", n_ret);
    end
    k = (n_ret > 63) ? 63 : ((n_ret < 2) ? 1 : n_ret - 1);
    n_vec++;
    if (ret_cyc[1] - ret_cyc[0] !== 2) begin
      n_bad++; $display("FAIL nop_latency got %0d want 2", ret_cyc[1] - ret_cyc[0]);
    end
    n_vec++;
    if (ret_cyc[k] - ret_cyc[k-1] !== 3) begin
      n_bad++; $display("FAIL beq_taken_latency got %0d want 3", ret_cyc[k] - ret_cyc[k-1]);
    end
    n_vec++;
    if (ret_pc[k] !== 16'd10 || ret_pc[k-1] !== 16'd10) begin
      n_bad++; $display("FAIL beq_taken_pc got %h/%h want 000a", ret_pc[k-1], ret_pc[k]);
    end
    do_reset();
    imem[0] = enc_i(4'h1, 2'd0, 2'd1, 8'd7);
    for (int i = 1; i < 10; i++) imem[i] = NOP;
    imem[10] = enc_i(4'h4, 2'd1, 2'd2, 8'hFF);  // r1 != r2: falls through
    start_cpu();
    wait_halt(300, ok);
    n_vec++;
    if (n_ret !== 11 || ret_pc[10] !== 16'd11) begin
      n_bad++; $display("FAIL beq_not_taken got retires=%0d pc=%h want 11/000b", n_ret, ret_pc[10]);
    end
    n_vec++;
    if (ret_cyc[10] - ret_cyc[9] !== 3) begin
      n_bad++; $display("FAIL beq_nt_latency got %0d want 3", ret_cyc[10] - ret_cyc[9]);
    end
    n_vec++;
    if (PcOut !== 16'd12) begin n_bad++; $display("FAIL beq_nt_final_pc got %h want 000c", PcOut); end
  endtask

  task automatic test_halt();
    bit ok;
    do_reset();
    imem[0] = enc_i(4'h1, 2'd0, 2'd1, 8'd9);
    for (int i = 1; i < 7; i++) imem[i] = NOP;
    imem[7] = HALT;
    start_cpu();
    wait_halt(200, ok);
    n_vec++;
    if ({Halted, Busy} !== 2'b10 || PcOut !== 16'd8) begin
      n_bad++; $display("FAIL halt_state got halted=%b busy=%b pc=%h want 1/0/0008", Halted, Busy,
                        PcOut);
    end
    n_vec++;
    if (n_ret !== 7) begin n_bad++; $display("FAIL halt_retires got %0d want 7", n_ret); end
    start_cpu();
    tick(5);
    n_vec++;
    if ({Halted, ImemReq, Busy} !== 3'b100 || PcOut !== 16'd8 || n_ret !== 7) begin
      n_bad++; $display("FAIL halt_start_ignored got h=%b req=%b busy=%b pc=%h ret=%0d want 1/0/0/0008/7",
                        Halted, ImemReq, Busy, PcOut, n_ret);
    end
    do_reset();
    DbgRegAddr = 2'd1; #1;
    n_vec++;
    if ({Halted, Busy} !== 2'b00 || PcOut !== 16'd0 || DbgRegData !== 16'h0) begin
      n_bad++; $display("FAIL halt_reset got h=%b busy=%b pc=%h r1=%h want 0/0/0000/0000", Halted,
                        Busy, PcOut, DbgRegData);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    imem[0] = enc_i(4'h2, 2'd0, 2'd1, 8'h20);   // LW r1 <- 0x7FFF
    imem[1] = enc_i(4'h1, 2'd1, 2'd1, 8'd1);    // ADDI r1,r1,1 overflows
    start_cpu();
    wait_halt(200, ok);
    DbgRegAddr = 2'd1; #1;
`ifdef DATAPATH_MC_OVF_TRAP_EN
    n_vec++;
    if ({Trap, Halted} !== 2'b11 || DbgRegData !== 16'h7FFF) begin
      n_bad++; $display("FAIL ovf_trap got trap=%b halted=%b r1=%h want 1/1/7fff", Trap, Halted,
                        DbgRegData);
    end
    n_vec++;
    if (n_ret !== 1 || PcOut !== 16'd2) begin
      n_bad++; $display("FAIL ovf_trap_retire got ret=%0d pc=%h want 1/0002", n_ret, PcOut);
    end
`else
    n_vec++;
    if ({Trap, Halted} !== 2'b01 || DbgRegData !== 16'h8000) begin
      n_bad++; $display("FAIL ovf_wrap got trap=%b halted=%b r1=%h want 0/1/8000", Trap, Halted,
                        DbgRegData);
    end
    n_vec++;
    if (n_ret !== 2 || PcOut !== 16'd3) begin
      n_bad++; $display("FAIL ovf_wrap_retire got ret=%0d pc=%h want 2/0003", n_ret, PcOut);
    end
`endif
    do_reset();
    n_vec++;
    if (Trap !== 1'b0) begin n_bad++; $display("FAIL ovf_reset_trap got %b want 0", Trap); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    imem_dly = 5;
    imem[0] = enc_i(4'h1, 2'd0, 2'd1, 8'd5);
    start_cpu();
    n_vec++;
    if ({ImemReq, Busy} !== 2'b11) begin
      n_bad++; $display("FAIL fetch_wait got req=%b busy=%b want 1/1", ImemReq, Busy);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ImemReq, Busy} !== 2'b00 || PcOut !== 16'd0) begin
      n_bad++; $display("FAIL async_reset got req=%b busy=%b pc=%h want 0/0/0000", ImemReq, Busy,
                        PcOut);
    end
    tick(2);
    Reset_n = 1'b1;
    imem_dly = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      imem[i] = HALT;
      dmem[i] = '0;
    end
    test_reset();
    test_addi();
    test_rtype();
    test_mem();
    test_beq();
    test_halt();
    test_overflow();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
